// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: MM:SS BCD counter driven by a tick divider, with
// run/pause/idle control and a lap-freeze display. Inputs are single-cycle
// pulses from the one-pulse stage; outputs feed the seven-segment scanner.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cleared, live time 00:00, divider held at 0
// RUN   | divider counting, live time advancing, lap freeze allowed
// PAUSE | divider and live time held, lap button clears to IDLE
module stopwatch_ctrl #(
   parameter int TICK_DIV = 100000000,
   parameter int CNT_W    = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_stop_pulse,
   input  logic       lap_reset_pulse,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       lap_active
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TICK_TC = CNT_W'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [15:0]      live_q, live_d;
   logic [15:0]      lap_q, lap_d;
   logic             lap_on_q, lap_on_d;
   logic [15:0]      disp_q, disp_d;
   logic             running_q, running_d;
   logic             tick_hit;

   // One-second BCD ripple increment of {min_tens, min_ones, sec_tens, sec_ones};
   // 59:59 wraps to 00:00.
   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = t;
      if (so != 4'd9) begin
         so = so + 4'd1;
      end else begin
         so = 4'd0;
         if (st != 4'd5) begin
            st = st + 4'd1;
         end else begin
            st = 4'd0;
            if (mo != 4'd9) begin
               mo = mo + 4'd1;
            end else begin
               mo = 4'd0;
               if (mt != 4'd5) begin
                  mt = mt + 4'd1;
               end else begin
                  mt = 4'd0;
               end
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   assign tick_hit = (state_q == RUN) && (tick_cnt_q == TICK_TC);

   // Next-state, divider, time and display computation.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      live_d     = live_q;
      lap_d      = lap_q;
      lap_on_d   = lap_on_q;

      // The divider advances on every edge taken while in RUN, including the
      // edge that leaves RUN, so a pause holds the already-advanced count.
      if (state_q == RUN) begin
         if (tick_hit) begin
            tick_cnt_d = '0;
            live_d     = bcd_inc(live_q);
         end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
         end
      end

      // start_stop_pulse has priority; a coincident lap pulse is dropped.
      unique case (state_q)
         IDLE: begin
            if (start_stop_pulse) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (start_stop_pulse) begin
               state_d  = PAUSE;
               lap_on_d = 1'b0;
            end else if (lap_reset_pulse) begin
               lap_on_d = ~lap_on_q;
               // Capture the pre-increment live time when freezing.
               if (!lap_on_q) begin
                  lap_d = live_q;
               end
            end
         end
         PAUSE: begin
            if (start_stop_pulse) begin
               state_d = RUN;
            end else if (lap_reset_pulse) begin
               state_d    = IDLE;
               tick_cnt_d = '0;
               live_d     = '0;
               lap_d      = '0;
               lap_on_d   = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            live_d     = '0;
            lap_d      = '0;
            lap_on_d   = 1'b0;
         end
      endcase

      // Display registers track the post-edge values so they never lag state.
      disp_d    = lap_on_d ? lap_d : live_d;
      running_d = (state_d == RUN);
   end

   // State, divider, time, lap and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         live_q     <= '0;
         lap_q      <= '0;
         lap_on_q   <= 1'b0;
         disp_q     <= '0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         live_q     <= live_d;
         lap_q      <= lap_d;
         lap_on_q   <= lap_on_d;
         disp_q     <= disp_d;
         running_q  <= running_d;
      end
   end

   assign {min_tens, min_ones, sec_tens, sec_ones} = disp_q;
   assign running    = running_q;
   assign lap_active = lap_on_q;

endmodule
